// File: rtl/uart_tx_arbiter_if.sv
// Request and serializer-side signals of uart_tx_arbiter.
// master: the arbiter; slave: the requesters and the serializer that surround it.
interface uart_tx_arbiter_if #(
   parameter int NUM_REQ = 4
);
   localparam int ID_W = $clog2(NUM_REQ);

   logic [NUM_REQ-1:0]   req_valid;
   logic [8*NUM_REQ-1:0] req_data;
   logic [NUM_REQ-1:0]   req_ready;
   logic [7:0]           tx_data;
   logic                 tx_start;
   logic                 busy;
   logic [ID_W-1:0]      grant_id;

   modport master (
      input  req_valid, req_data,
      output req_ready, tx_data, tx_start, busy, grant_id
   );

   modport slave (
      output req_valid, req_data,
      input  req_ready, tx_data, tx_start, busy, grant_id
   );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx serializer among NUM_REQ byte producers.
// Define UART_TX_ARB_TAG_EN to send a requester tag frame (TAG_BASE + id) ahead of each payload.
//
// state      | meaning
// HOLDOFF    | after reset, wait one full frame so a serializer caught mid-frame can finish
// IDLE       | arbitrate; grant and latch the winner's byte in the same cycle
// TAG_SEND   | strobe the tag byte into the serializer (tag build only)
// TAG_WAIT   | let the tag frame drain (tag build only)
// SEND       | strobe the payload byte into the serializer
// WAIT       | let the payload frame drain, then return to IDLE
module uart_tx_arbiter #(
   parameter int         NUM_REQ    = 4,
   parameter int         BD_DIVIDER = 2500,
   parameter int         FRAME_GAP  = 2,
   parameter logic [7:0] TAG_BASE   = 8'h30
) (
   input  logic              clk,
   input  logic              rst,
   uart_tx_arbiter_if.master arb
);
   localparam int ID_W         = $clog2(NUM_REQ);
   localparam int FRAME_CYCLES = 10*BD_DIVIDER + FRAME_GAP;
   localparam int CNT_W        = $clog2(FRAME_CYCLES+1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_CYCLES-1);
`ifdef UART_TX_ARB_TAG_EN
   localparam bit TAG_EN = 1'b1;
`else
   localparam bit TAG_EN = 1'b0;
`endif

   typedef enum logic [2:0] {
      S_HOLDOFF,
      S_IDLE,
      S_SEND,
`ifdef UART_TX_ARB_TAG_EN
      S_WAIT,
      S_TAG_SEND,
      S_TAG_WAIT
`else
      S_WAIT
`endif
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q;
   logic [ID_W-1:0]  ptr_q, ptr_nxt, win_id, scan_idx, grant_id_q;
   logic [7:0]       tx_data_q, payload_q, win_byte, tag_byte;
   logic             any_valid, grant, load_payload, counting, cnt_last, tx_start_c;

   // Scan downward so the last hit, i.e. the first one at or after the pointer, wins.
   always_comb begin
      any_valid = 1'b0;
      win_id    = '0;
      scan_idx  = '0;
      for (int k = NUM_REQ-1; k >= 0; k--) begin
         scan_idx = ID_W'((int'(ptr_q) + k) % NUM_REQ);
         if (arb.req_valid[scan_idx]) begin
            any_valid = 1'b1;
            win_id    = scan_idx;
         end
      end
   end

   always_comb begin
      win_byte = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (ID_W'(k) == win_id) win_byte = arb.req_data[8*k +: 8];
      end
   end

   assign tag_byte = TAG_BASE + 8'(win_id);
   assign ptr_nxt  = (win_id == ID_W'(NUM_REQ-1)) ? '0 : win_id + 1'b1;
   assign cnt_last = (cnt_q == CNT_LAST);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= S_HOLDOFF;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d      = state_q;
      grant        = 1'b0;
      load_payload = 1'b0;
      counting     = 1'b0;
      tx_start_c   = 1'b0;
      case (state_q)
         S_HOLDOFF: begin
            counting = 1'b1;
            if (cnt_last) state_d = S_IDLE;
         end
         S_IDLE: begin
            if (any_valid) begin
               grant = 1'b1;
`ifdef UART_TX_ARB_TAG_EN
               state_d = S_TAG_SEND;
`else
               state_d = S_SEND;
`endif
            end
         end
         S_SEND: begin
            tx_start_c = 1'b1;
            state_d    = S_WAIT;
         end
         S_WAIT: begin
            counting = 1'b1;
            if (cnt_last) state_d = S_IDLE;
         end
`ifdef UART_TX_ARB_TAG_EN
         S_TAG_SEND: begin
            tx_start_c = 1'b1;
            state_d    = S_TAG_WAIT;
         end
         S_TAG_WAIT: begin
            counting = 1'b1;
            if (cnt_last) begin
               state_d      = S_SEND;
               load_payload = 1'b1;
            end
         end
`endif
         default: state_d = S_HOLDOFF;
      endcase
   end

   // tx_data only changes on the edge that enters a strobe state, so it is stable from
   // one tx_start to the next.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q      <= '0;
         ptr_q      <= '0;
         grant_id_q <= '0;
         tx_data_q  <= '0;
         payload_q  <= '0;
      end else begin
         cnt_q <= (counting && !cnt_last) ? cnt_q + 1'b1 : '0;
         if (grant) begin
            ptr_q      <= ptr_nxt;
            grant_id_q <= win_id;
            payload_q  <= win_byte;
            tx_data_q  <= TAG_EN ? tag_byte : win_byte;
         end
         if (load_payload) tx_data_q <= payload_q;
      end
   end

   always_comb begin
      arb.req_ready = '0;
      if (grant) arb.req_ready[win_id] = 1'b1;
   end

   assign arb.tx_start = tx_start_c;
   assign arb.tx_data  = tx_data_q;
   assign arb.busy     = (state_q != S_IDLE);
   assign arb.grant_id = grant_id_q;
endmodule
